// File: rtl/diff_pkg.sv
`default_nettype none
// ============================================================================
// Module  : diff_pkg
// Purpose : Shared definitions for the diff_kernel block. Holds the one-hot
//           state encoding of the kernel FSM and the default geometry
//           (data width, address width, memory depth).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package diff_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int ADDR_W_DEFAULT = 8;
    localparam int DEPTH_DEFAULT  = 256;

    // One-hot encoding, matching the sibling prefix-sum kernel.
    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_CHECK   = 5'b00010,
        ST_RD_WAIT = 5'b00100,
        ST_CALC    = 5'b01000,
        ST_RET     = 5'b10000
    } state_e;

endpackage : diff_pkg
`default_nettype wire

// File: rtl/diff_kernel.sv
`default_nettype none
// ============================================================================
// Module  : diff_kernel
// Purpose : Inverse prefix-sum. Reads b[0..n-1] from an external memory and
//           writes a[i] = b[i] - b[i-1] (b[-1] = 0) back through a write
//           port, one element every 3 cycles. Returns a[n-1].
// Ports   : sys_clk, sys_rst_n     - clock, asynchronous active-low reset
//           start, n               - run request (sampled in IDLE), count
//           rd_addr, rd_data       - b memory read port, 1-cycle latency
//           wr_en, wr_addr, wr_data- a memory write port (one strobe/element)
//           busy, done, return_val - status, done pulse, a[n-1]
//           mismatch               - only with DIFF_SELFCHECK_EN defined
// Options : DIFF_SELFCHECK_EN - adds a running sum of written values and
//           flags when it disagrees with the last b value read.
// Revision: 1.0 - initial release
// ============================================================================
module diff_kernel
    import diff_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] n,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] return_val
`ifdef DIFF_SELFCHECK_EN
    ,
    output logic              mismatch
`endif
);

    localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] i_q, i_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] n_lat_q, n_lat_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] ret_q, ret_d;
    logic [DATA_W-1:0] diff;

`ifdef DIFF_SELFCHECK_EN
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              mismatch_q, mismatch_d;
`endif

    // rd_data is only meaningful in CALC; outside it the result is unused.
    assign diff = rd_data - prev_q;

    // ------------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        prev_d    = prev_q;
        last_d    = last_q;
        n_lat_d   = n_lat_q;
        rd_addr_d = rd_addr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ret_d     = ret_q;
`ifdef DIFF_SELFCHECK_EN
        acc_d      = acc_q;
        mismatch_d = mismatch_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Clamp so addresses never wrap past the memory.
                    n_lat_d = (n > DEPTH_W) ? DEPTH_W : n;
                    i_d     = '0;
                    prev_d  = '0;
                    last_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_CHECK;
`ifdef DIFF_SELFCHECK_EN
                    acc_d      = '0;
                    mismatch_d = 1'b0;
`endif
                end
            end
            ST_CHECK: begin
                if (i_q >= n_lat_q) begin
                    state_d = ST_RET;
                end else begin
                    rd_addr_d = i_q[ADDR_W-1:0];
                    state_d   = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                state_d = ST_CALC;
            end
            ST_CALC: begin
                prev_d  = rd_data;
                last_d  = diff;
                i_d     = i_q + 1'b1;
                state_d = ST_CHECK;
`ifdef DIFF_SELFCHECK_EN
                acc_d = acc_q + diff;
`endif
            end
            ST_RET: begin
                ret_d   = last_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
`ifdef DIFF_SELFCHECK_EN
                // prev_q holds the last b value read in this run.
                mismatch_d = (n_lat_q != '0) && (acc_q != prev_q);
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            i_q       <= '0;
            prev_q    <= '0;
            last_q    <= '0;
            n_lat_q   <= '0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ret_q     <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            prev_q    <= prev_d;
            last_q    <= last_d;
            n_lat_q   <= n_lat_d;
            rd_addr_q <= rd_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ret_q     <= ret_d;
        end
    end

`ifdef DIFF_SELFCHECK_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`endif

    // ------------------------------------------------------------------------
    // Outputs. The write port is driven only while in CALC, where rd_data
    // carries the b value requested two edges earlier; it is forced to zero
    // elsewhere so nothing leaks out during reset or idle.
    // ------------------------------------------------------------------------
    assign rd_addr    = rd_addr_q;
    assign wr_en      = (state_q == ST_CALC);
    assign wr_addr    = (state_q == ST_CALC) ? i_q[ADDR_W-1:0] : '0;
    assign wr_data    = (state_q == ST_CALC) ? diff : '0;
    assign busy       = busy_q;
    assign done       = done_q;
    assign return_val = ret_q;

endmodule : diff_kernel
`default_nettype wire

// File: doc/diff_kernel.md
Name: diff_kernel

Overview:
- Inverse of the prefix-sum kernel: reads a prefix-sum array b[0..n-1] from a data memory and writes back the recovered element array a[i] = b[i] - b[i-1], with b[-1] = 0.
- Returns a[n-1].
- Sits beside the prefix-sum kernel as a generated-style FSM block. Uses an explicit start/done handshake and external memory ports instead of internal $readmemh arrays, so a bench or top level can chain it after the encoder.

Parameters:
- DATA_W, 32, width of n, data words and return value.
- ADDR_W, 8, memory address width.
- DEPTH, 256, number of memory words; the effective element count is min(n, DEPTH).

Ports:
- sys_clk  input  1  single clock; all state changes on the rising edge.
- sys_rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to run; sampled only in IDLE.
- n  input  DATA_W  element count; latched on the accepted start.
- rd_addr  output  ADDR_W  read address into the b memory.
- rd_data  input  DATA_W  b memory read data, valid exactly one cycle after rd_addr is presented.
- wr_en  output  1  a memory write strobe, one cycle per element.
- wr_addr  output  ADDR_W  a memory write address.
- wr_data  output  DATA_W  a memory write data.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  single-cycle pulse when the result is valid.
- return_val  output  DATA_W  a[n-1]; holds until the next accepted start.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - rd_addr, wr_en, wr_addr, wr_data, busy, done, return_val = 0.
  - Internal i, prev, last, n_lat = 0.
  - An operation in flight is abandoned; no further writes are issued.
- States:
  - IDLE: on start=1, latch n_lat = min(n, DEPTH); set i=0, prev=0, last=0, busy=1; go to CHECK. Otherwise stay.
  - CHECK: if i >= n_lat, go to RET. Else drive rd_addr=i and go to RD_WAIT.
  - RD_WAIT: one-cycle memory latency; go to CALC.
  - CALC: wr_en=1, wr_addr=i, wr_data = rd_data - prev; prev=rd_data; last = rd_data - prev; i=i+1; go to CHECK. wr_en is high only during CALC.
  - RET: return_val=last, done=1, busy=0; go to IDLE. done drops on the next edge.
- Latency: done is high in the cycle beginning 3*n_lat+2 edges after the edge that accepted start (n_lat=0 gives 2).
- Throughput: one element per 3 cycles.
- Arithmetic: subtraction is modulo 2^DATA_W (wrap, no saturation).
- n=0: no reads or writes; return_val=0.
- n > DEPTH: clamp to DEPTH; addresses never wrap.
- start while busy: ignored, not queued.
- start held high in IDLE after done: starts a new run immediately.
- n changing after acceptance: no effect.
- rd_data is sampled only in CALC. rd_addr holds its last value outside CHECK.

Optional Feature:
- Macro: DIFF_SELFCHECK_EN.
- Defined:
  - Extra output port mismatch (1 bit, reset 0).
  - Internal accumulator sums every wr_data written during the run.
  - In RET, mismatch = (accumulator != last rd_data value read, or 0 when n_lat=0); mismatch holds until the next accepted start.
  - This catches memory read-latency or corruption faults.
- Undefined: no port, no accumulator, no logic.

Decomposition:
- Package diff_pkg:
  - state encoding constants ST_IDLE, ST_CHECK, ST_RD_WAIT, ST_CALC, ST_RET (one-hot, 5 bits, matching the kernel style).
  - Default DATA_W/ADDR_W/DEPTH constants.
- Single module. A sub-module is not warranted; the datapath is one subtractor and three registers.

Test Plan:
- b = {1,3,6,10}, n=4, start pulse -> writes a = {1,2,3,4} at addr 0..3, one write every 3 cycles; done in cycle 14 after start; return_val=4.
- n=0 -> no wr_en pulse; done 2 cycles after start; return_val=0.
- b = {0xFFFFFFFF, 0x00000001}, n=2 -> a = {0xFFFFFFFF, 0x00000002} (wraparound); return_val=2.
- n=300 with DEPTH=256 -> exactly 256 writes, last to addr 255; done at 3*256+2 = 770 cycles.
- start re-pulsed mid-run, then sys_rst_n asserted mid-run at element 2 -> second start ignored. At reset: all outputs 0 asynchronously, no further wr_en; a subsequent start with n=4 completes correctly.
- DIFF_SELFCHECK_EN with the bench delaying rd_data by 2 cycles instead of 1 -> mismatch=1 after done; with correct latency -> mismatch=0.
